// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between the ALU (source 0) and the load unit (source 1)
// with round-robin arbitration, a one-cycle output register and a pending-write scoreboard.
module regfile_write_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  aluValid,
    output logic                  aluReady,
    input  logic [ADDR_WIDTH-1:0] aluRegister,
    input  logic [DATA_WIDTH-1:0] aluData,
    input  logic                  memValid,
    output logic                  memReady,
    input  logic [ADDR_WIDTH-1:0] memRegister,
    input  logic [DATA_WIDTH-1:0] memData,
    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] issueRegister,
    input  logic [ADDR_WIDTH-1:0] register1,
    input  logic [ADDR_WIDTH-1:0] register2,
    output logic                  stall,
    output logic [ADDR_WIDTH:0]   pendingCount,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0] writeData
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    logic                  r_last_grant;
    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_write_register;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic [NUM_REGS-1:0]   r_pending;
    logic [CNT_W-1:0]      r_pending_count;

    logic                  w_alu_grant;
    logic                  w_mem_grant;
    logic                  w_any_grant;
    logic [ADDR_WIDTH-1:0] w_sel_register;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [NUM_REGS-1:0]   w_set_mask;
    logic [NUM_REGS-1:0]   w_clear_mask;
    logic [NUM_REGS-1:0]   w_next_pending;

    // Round-robin arbiter: r_last_grant=1 means the load unit won last, so the ALU wins a tie.
    always_comb begin
        w_alu_grant = 1'b0;
        w_mem_grant = 1'b0;
        if (aluValid && memValid) begin
            if (r_last_grant) begin
                w_alu_grant = 1'b1;
            end else begin
                w_mem_grant = 1'b1;
            end
        end else begin
            w_alu_grant = aluValid;
            w_mem_grant = memValid;
        end
    end

    // Winner's destination and data, steered toward the output register.
    always_comb begin
        w_any_grant = w_alu_grant | w_mem_grant;
        if (w_mem_grant) begin
            w_sel_register = memRegister;
            w_sel_data     = memData;
        end else begin
            w_sel_register = aluRegister;
            w_sel_data     = aluData;
        end
    end

    // Scoreboard update: the clear comes from the write being presented now; a same-cycle issue wins.
    always_comb begin
        w_set_mask   = {NUM_REGS{1'b0}};
        w_clear_mask = {NUM_REGS{1'b0}};
        if (r_reg_write) begin
            w_clear_mask[r_write_register] = 1'b1;
        end else begin
            w_clear_mask = {NUM_REGS{1'b0}};
        end
        if (issueValid) begin
            w_set_mask[issueRegister] = 1'b1;
        end else begin
            w_set_mask = {NUM_REGS{1'b0}};
        end
        w_next_pending    = (r_pending & ~w_clear_mask) | w_set_mask;
        w_next_pending[0] = 1'b0;
    end

    // Output stage: a granted write to register 0 still completes but never asserts regWrite.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_reg_write      <= 1'b0;
            r_write_register <= {ADDR_WIDTH{1'b0}};
            r_write_data     <= {DATA_WIDTH{1'b0}};
            r_last_grant     <= 1'b1;
        end else if (w_any_grant) begin
            r_reg_write      <= (w_sel_register != {ADDR_WIDTH{1'b0}});
            r_write_register <= w_sel_register;
            r_write_data     <= w_sel_data;
            r_last_grant     <= w_mem_grant;
        end else begin
            r_reg_write      <= 1'b0;
        end
    end

    // Pending mask and its population count are registered together so they always agree.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending       <= {NUM_REGS{1'b0}};
            r_pending_count <= {CNT_W{1'b0}};
        end else begin
            r_pending       <= w_next_pending;
            r_pending_count <= popcount(w_next_pending);
        end
    end

    assign aluReady      = w_alu_grant;
    assign memReady      = w_mem_grant;
    assign stall         = r_pending[register1] | r_pending[register2];
    assign pendingCount  = r_pending_count;
    assign regWrite      = r_reg_write;
    assign writeRegister = r_write_register;
    assign writeData     = r_write_data;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed plus randomized bench for regfile_write_scheduler, checked against a
// behavioural model holding the pending set, last winner and the expected write port.
module tb_regfile_write_scheduler;

    logic        clock;
    logic        reset;
    logic        aluValid;
    logic        aluReady;
    logic [4:0]  aluRegister;
    logic [31:0] aluData;
    logic        memValid;
    logic        memReady;
    logic [4:0]  memRegister;
    logic [31:0] memData;
    logic        issueValid;
    logic [4:0]  issueRegister;
    logic [4:0]  register1;
    logic [4:0]  register2;
    logic        stall;
    logic [5:0]  pendingCount;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_pending [32];
    bit          m_last_mem;
    bit          m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    bit          g_alu;
    bit          g_mem;

    regfile_write_scheduler dut (
        .clock(clock), .reset(reset),
        .aluValid(aluValid), .aluReady(aluReady), .aluRegister(aluRegister), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memRegister(memRegister), .memData(memData),
        .issueValid(issueValid), .issueRegister(issueRegister),
        .register1(register1), .register2(register2), .stall(stall), .pendingCount(pendingCount),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        foreach (m_pending[i]) n += m_pending[i];
        return n;
    endfunction

    function automatic void model_reset();
        foreach (m_pending[i]) m_pending[i] = 1'b0;
        m_last_mem = 1'b1;
        m_rw = 1'b0;
        m_wr = 5'd0;
        m_wd = 32'd0;
    endfunction

    task automatic idle_inputs();
        aluValid = 1'b0; aluRegister = 5'd0; aluData = 32'd0;
        memValid = 1'b0; memRegister = 5'd0; memData = 32'd0;
        issueValid = 1'b0; issueRegister = 5'd0;
        register1 = 5'd0; register2 = 5'd0;
    endtask

    // One clock: check combinational outputs, advance the model at the edge, check registered outputs.
    task automatic cycle(input string tag);
        bit exp_stall;
        #1;
        if (aluValid && memValid) begin
            g_alu = m_last_mem;
            g_mem = !m_last_mem;
        end else begin
            g_alu = aluValid;
            g_mem = memValid;
        end
        exp_stall = m_pending[register1] || m_pending[register2];
        chk({tag, ".aluReady"}, {31'd0, aluReady}, {31'd0, g_alu});
        chk({tag, ".memReady"}, {31'd0, memReady}, {31'd0, g_mem});
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
        @(posedge clock);
        if (m_rw) m_pending[m_wr] = 1'b0;
        if (issueValid && issueRegister != 5'd0) m_pending[issueRegister] = 1'b1;
        if (g_alu || g_mem) begin
            m_wr = g_mem ? memRegister : aluRegister;
            m_wd = g_mem ? memData : aluData;
            m_rw = (m_wr != 5'd0);
            m_last_mem = g_mem;
        end else begin
            m_rw = 1'b0;
        end
        #1;
        chk({tag, ".regWrite"}, {31'd0, regWrite}, {31'd0, m_rw});
        if (m_rw) begin
            chk({tag, ".writeRegister"}, {27'd0, writeRegister}, {27'd0, m_wr});
            chk({tag, ".writeData"}, writeData, m_wd);
        end
        chk({tag, ".pendingCount"}, {26'd0, pendingCount}, model_count());
    endtask

    initial begin
        bit keep_alu;
        bit keep_mem;
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        reset = 1'b1;
        #1;
        chk("reset.regWrite", {31'd0, regWrite}, 32'd0);
        chk("reset.writeRegister", {27'd0, writeRegister}, 32'd0);
        chk("reset.writeData", writeData, 32'd0);
        chk("reset.pendingCount", {26'd0, pendingCount}, 32'd0);

        // Reset while a granted ALU write to r5 and an issue of r5 are in flight
        aluValid = 1'b1; aluRegister = 5'd5; aluData = 32'h1234_5678;
        issueValid = 1'b1; issueRegister = 5'd5;
        #1;
        chk("midreset.aluReady", {31'd0, aluReady}, 32'd1);
        @(posedge clock);
        idle_inputs();
        register1 = 5'd5;
        #2;
        reset = 1'b0;
        #1;
        chk("midreset.regWrite", {31'd0, regWrite}, 32'd0);
        chk("midreset.pendingCount", {26'd0, pendingCount}, 32'd0);
        chk("midreset.stall", {31'd0, stall}, 32'd0);
        #3;
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;

        // Contention: ALU wins first after reset, then strict alternation
        aluValid = 1'b1; aluRegister = 5'd1; aluData = 32'h0000_0011;
        memValid = 1'b1; memRegister = 5'd2; memData = 32'h0000_0022;
        cycle("cont0");
        chk("cont0.firstIsAlu", {31'd0, regWrite & (writeRegister == 5'd1)}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            aluData = 32'h0000_0011 + 32'(i);
            memData = 32'h0000_0022 + 32'(i);
            cycle("cont");
        end
        idle_inputs();
        cycle("cont.drain");

        // Single source write to r3
        aluValid = 1'b1; aluRegister = 5'd3; aluData = 32'h0000_00AA;
        cycle("single");
        idle_inputs();
        cycle("single.after");

        // Scoreboard: reserve r7, stall until the cycle after its commit
        issueValid = 1'b1; issueRegister = 5'd7;
        cycle("sb.issue");
        idle_inputs();
        register1 = 5'd7;
        memValid = 1'b1; memRegister = 5'd7; memData = 32'hCAFE_0007;
        cycle("sb.grant");
        memValid = 1'b0;
        cycle("sb.commit");
        cycle("sb.cleared");

        // Set/clear collision on r9
        idle_inputs();
        issueValid = 1'b1; issueRegister = 5'd9;
        cycle("coll.issue");
        issueValid = 1'b0;
        aluValid = 1'b1; aluRegister = 5'd9; aluData = 32'h9999_0009;
        cycle("coll.grant");
        aluValid = 1'b0;
        issueValid = 1'b1; issueRegister = 5'd9;
        register1 = 5'd9;
        cycle("coll.commit");
        idle_inputs();
        register1 = 5'd9;
        cycle("coll.after");

        // Register 0: issue and write are both ignored by the write port and scoreboard
        idle_inputs();
        issueValid = 1'b1; issueRegister = 5'd0;
        aluValid = 1'b1; aluRegister = 5'd0; aluData = 32'hFFFF_FFFF;
        cycle("r0");
        idle_inputs();
        cycle("r0.after");

        // Randomized traffic; a source holds its request until the model says it was granted
        keep_alu = 1'b0;
        keep_mem = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!keep_alu) begin
                aluValid = ($urandom_range(0, 99) < 55);
                aluRegister = 5'($urandom_range(0, 31));
                aluData = $urandom;
            end
            if (!keep_mem) begin
                memValid = ($urandom_range(0, 99) < 55);
                memRegister = 5'($urandom_range(0, 31));
                memData = $urandom;
            end
            issueValid = ($urandom_range(0, 99) < 40);
            issueRegister = 5'($urandom_range(0, 31));
            register1 = 5'($urandom_range(0, 31));
            register2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            cycle("rand");
            keep_alu = aluValid && !g_alu;
            keep_mem = memValid && !g_mem;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
